// File: rtl/ocr_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ocr_ctrl_pkg : shared state encoding and frame constants for OCR   |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
package ocr_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_WAIT_FULL  = 3'd2,
    ST_INFER      = 3'd3,
    ST_WAIT_INFER = 3'd4,
    ST_RESULT     = 3'd5,
    ST_CLEAR      = 3'd6
  } ctrl_state_t;

  localparam int         IMG_BYTES = 113;
  localparam logic [3:0] ERR_DIGIT = 4'hF;

endpackage
`default_nettype wire

// File: rtl/inference_watchdog.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | inference_watchdog : down-counter bounding the BNN inference time  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module inference_watchdog #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic enable,
  output logic expired
);

  logic [16:0] count;

  // The load cycle (start pulse) is the first counted cycle, so the
  // controller leaves WAIT_INFER exactly TIMEOUT_CYCLES after the pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= 17'(TIMEOUT_CYCLES - 1);
    end else if (!enable) begin
      count <= '0;
    end else if (count != 17'd0) begin
      count <= count - 17'd1;
    end
  end

  assign expired = enable && (count <= 17'd1);

endmodule
`default_nettype wire

// File: rtl/image_load_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | image_load_ctrl : loads one 113-byte frame, runs one inference     |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module image_load_ctrl
  import ocr_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int FULL_WAIT_MAX  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_ready,
  input  logic       abort,
  output logic       buf_clear,
  output logic       buf_we,
  output logic [7:0] buf_data,
  input  logic       buf_full,
  input  logic       buf_empty,
  output logic       infer_start,
  input  logic       infer_done,
  input  logic [3:0] infer_result,
  output logic       result_valid,
  output logic [3:0] result_data,
  input  logic       result_ack,
  output logic       error,
  output logic       busy
);

  ctrl_state_t state, state_nxt;
  logic [6:0]  byte_cnt, byte_cnt_nxt;
  logic        wr_pend, wr_pend_nxt;
  logic [7:0]  wr_data, wr_data_nxt;
  logic [2:0]  full_wait, full_wait_nxt;
  logic        err_q, err_nxt;
  logic [3:0]  digit_q, digit_nxt;
  logic [7:0]  accepted;
  logic        wd_expired;

  inference_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (state == ST_INFER),
    .enable (state == ST_WAIT_INFER),
    .expired(wd_expired)
  );

  // Bytes accepted so far, including the one still waiting to be written.
  assign accepted = {1'b0, byte_cnt} + {7'd0, wr_pend};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      byte_cnt  <= '0;
      wr_pend   <= 1'b0;
      wr_data   <= '0;
      full_wait <= '0;
      err_q     <= 1'b0;
      digit_q   <= '0;
    end else begin
      state     <= state_nxt;
      byte_cnt  <= byte_cnt_nxt;
      wr_pend   <= wr_pend_nxt;
      wr_data   <= wr_data_nxt;
      full_wait <= full_wait_nxt;
      err_q     <= err_nxt;
      digit_q   <= digit_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    byte_cnt_nxt  = wr_pend ? byte_cnt + 7'd1 : byte_cnt;
    wr_pend_nxt   = 1'b0;
    wr_data_nxt   = wr_data;
    full_wait_nxt = '0;
    err_nxt       = err_q;
    digit_nxt     = digit_q;
    rx_ready      = 1'b0;

    case (state)
      ST_IDLE: state_nxt = buf_empty ? ST_LOAD : ST_CLEAR;
      ST_LOAD: begin
        // A full flag while still loading means the buffer lost sync.
        rx_ready = !abort && !buf_full;
        if (buf_full) begin
          err_nxt   = 1'b1;
          digit_nxt = ERR_DIGIT;
          state_nxt = ST_RESULT;
        end else if (rx_valid && rx_ready) begin
          wr_pend_nxt = 1'b1;
          wr_data_nxt = rx_data;
          if (accepted == 8'(IMG_BYTES - 1)) state_nxt = ST_WAIT_FULL;
        end
      end
      ST_WAIT_FULL: begin
        if (buf_full) begin
          state_nxt = ST_INFER;
        end else if (full_wait == 3'(FULL_WAIT_MAX - 1)) begin
          err_nxt   = 1'b1;
          digit_nxt = ERR_DIGIT;
          state_nxt = ST_RESULT;
        end else begin
          full_wait_nxt = full_wait + 3'd1;
        end
      end
      ST_INFER: state_nxt = ST_WAIT_INFER;
      ST_WAIT_INFER: begin
        if (infer_done) begin
          digit_nxt = infer_result;
          state_nxt = ST_RESULT;
        end else if (wd_expired) begin
          err_nxt   = 1'b1;
          digit_nxt = ERR_DIGIT;
          state_nxt = ST_RESULT;
        end
      end
      ST_RESULT: if (result_ack) state_nxt = ST_CLEAR;
      ST_CLEAR: begin
        byte_cnt_nxt = '0;
        err_nxt      = 1'b0;
        state_nxt    = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Abort overrides any same-cycle result or error capture.
    if (abort && (state != ST_IDLE) && (state != ST_CLEAR)) begin
      state_nxt = ST_CLEAR;
      err_nxt   = err_q;
      digit_nxt = digit_q;
    end
  end

  assign buf_we       = wr_pend;
  assign buf_data     = wr_data;
  assign buf_clear    = (state == ST_CLEAR);
  assign infer_start  = (state == ST_INFER);
  assign result_valid = (state == ST_RESULT);
  assign result_data  = digit_q;
  assign error        = err_q;
  assign busy         = (state != ST_IDLE);

endmodule
`default_nettype wire
